// File: rtl/multi_channel_bin2ascii.sv
// Converts N_CH two's-complement samples to signed-magnitude ASCII decimal.
// A single double-dabble engine walks the channels in order. All results are published together from one capture.
//   state | meaning
//   IDLE  | waiting for in_valid; ready high
//   LOAD  | latch sign and magnitude of current channel, clear BCD
//   SHIFT | one shift-add-3 iteration per cycle, BIN_W cycles
//   STORE | format digits into the channel's shadow slot
//   DONE  | publish all shadows, pulse out_valid
module multi_channel_bin2ascii #(
  parameter int N_CH       = 4,
  parameter int BIN_W      = 13,
  parameter int N_DIG      = 4,
  parameter int LEAD_BLANK = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [N_CH*BIN_W-1:0]   bin_in,
  output logic [N_CH*N_DIG*8-1:0] ascii_out,
  output logic [N_CH-1:0]         is_negative,
  output logic [N_CH-1:0]         saturated,
  output logic                    ready,
  output logic                    out_valid,
  output logic                    overrun
);

  function automatic int calc_dig(input int w);
    longint unsigned v;
    int n;
    v = 64'd1 << w;
    n = 0;
    while (v != 0) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

  // BCD holds 2^BIN_W; widened to N_DIG so every output digit is indexable
  localparam int BCD_DIG = calc_dig(BIN_W);
  localparam int EXT_DIG = (BCD_DIG > N_DIG) ? BCD_DIG : N_DIG;
  localparam int EXT_W   = EXT_DIG * 4;
  localparam int CNT_W   = $clog2(BIN_W);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t               state, state_next;
  logic [BIN_W-1:0]     hold [N_CH];
  logic [CH_W-1:0]      ch_idx;
  logic                 sign_r;
  logic [BIN_W-1:0]     mag;
  logic [EXT_W-1:0]     bcd;
  logic [CNT_W-1:0]     bit_cnt;
  logic [N_DIG*8-1:0]   sh_ascii [N_CH];
  logic [N_CH-1:0]      sh_neg;
  logic [N_CH-1:0]      sh_sat;

  logic [BIN_W-1:0]     sample;
  logic [EXT_W-1:0]     bcd_adj;
  logic [N_DIG*8-1:0]   st_ascii;
  logic                 st_sat;
  logic                 blank;
  logic [3:0]           digit;

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (enable) begin
      unique case (state)
        IDLE:    if (in_valid) state_next = LOAD;
        LOAD:    state_next = SHIFT;
        SHIFT:   if (bit_cnt == LAST_BIT) state_next = STORE;
        STORE:   state_next = (ch_idx == LAST_CH) ? DONE : LOAD;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    sample = hold[ch_idx];
    bcd_adj = bcd;
    for (int d = 0; d < EXT_DIG; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  // Saturation is any nonzero BCD digit above the displayed ones
  always_comb begin
    st_sat   = 1'b0;
    st_ascii = '0;
    digit    = '0;
    for (int d = N_DIG; d < EXT_DIG; d++) begin
      if (bcd[d*4 +: 4] != 4'd0) st_sat = 1'b1;
    end
    blank = (LEAD_BLANK != 0) && !st_sat;
    for (int d = N_DIG - 1; d >= 0; d--) begin
      digit = bcd[d*4 +: 4];
      if (st_sat) begin
        st_ascii[d*8 +: 8] = 8'h39;
      end else if (blank && (digit == 4'd0) && (d != 0)) begin
        st_ascii[d*8 +: 8] = 8'h20;
      end else begin
        st_ascii[d*8 +: 8] = 8'h30 + {4'h0, digit};
        blank = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    out_valid <= 1'b0;
    overrun   <= 1'b0;
    if (reset) begin
      ch_idx      <= '0;
      sign_r      <= 1'b0;
      mag         <= '0;
      bcd         <= '0;
      bit_cnt     <= '0;
      sh_neg      <= '0;
      sh_sat      <= '0;
      ascii_out   <= {(N_CH*N_DIG){8'h30}};
      is_negative <= '0;
      saturated   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        hold[c]     <= '0;
        sh_ascii[c] <= {N_DIG{8'h30}};
      end
    end else if (enable) begin
      overrun <= in_valid && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int c = 0; c < N_CH; c++) hold[c] <= bin_in[c*BIN_W +: BIN_W];
            ch_idx <= '0;
          end
        end
        LOAD: begin
          sign_r  <= sample[BIN_W-1];
          mag     <= sample[BIN_W-1] ? (~sample + BIN_W'(1)) : sample;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          bit_cnt    <= bit_cnt + CNT_W'(1);
        end
        STORE: begin
          sh_ascii[ch_idx] <= st_ascii;
          sh_neg[ch_idx]   <= sign_r;
          sh_sat[ch_idx]   <= st_sat;
          if (ch_idx != LAST_CH) ch_idx <= ch_idx + CH_W'(1);
        end
        DONE: begin
          for (int c = 0; c < N_CH; c++) ascii_out[c*N_DIG*8 +: N_DIG*8] <= sh_ascii[c];
          is_negative <= sh_neg;
          saturated   <= sh_sat;
          out_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_bin2ascii.sv
// Directed bench for multi_channel_bin2ascii: defaults, LEAD_BLANK=1, and N_DIG=3 with blanking.
// All three instances share stimulus; expected strings are hand-computed.
module tb_multi_channel_bin2ascii;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic [51:0]  bin_in;

  logic [127:0] ascii_d, ascii_lb;
  logic [95:0]  ascii_n3;
  logic [3:0]   neg_d, neg_lb, neg_n3;
  logic [3:0]   sat_d, sat_lb, sat_n3;
  logic         ready, ready_lb, ready_n3;
  logic         out_valid, out_valid_lb, out_valid_n3;
  logic         overrun, overrun_lb, overrun_n3;

  int checks = 0;
  int errors = 0;
  int ov_pulses = 0;
  int lat;
  int snap;

  multi_channel_bin2ascii dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .bin_in(bin_in),
    .ascii_out(ascii_d), .is_negative(neg_d), .saturated(sat_d),
    .ready(ready), .out_valid(out_valid), .overrun(overrun)
  );

  multi_channel_bin2ascii #(.LEAD_BLANK(1)) dut_lb (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .bin_in(bin_in),
    .ascii_out(ascii_lb), .is_negative(neg_lb), .saturated(sat_lb),
    .ready(ready_lb), .out_valid(out_valid_lb), .overrun(overrun_lb)
  );

  multi_channel_bin2ascii #(.N_DIG(3), .LEAD_BLANK(1)) dut_n3 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .bin_in(bin_in),
    .ascii_out(ascii_n3), .is_negative(neg_n3), .saturated(sat_n3),
    .ready(ready_n3), .out_valid(out_valid_n3), .overrun(overrun_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) ov_pulses++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Capture v, optionally re-strobe in_valid at edge dup_edge and hold enable low
  // for off_len edges starting at off_start; edges counted from the capture edge.
  task automatic run_conv(input logic [51:0] v, input int dup_edge, input int off_start,
                          input int off_len, input int exp_lat);
    int k;
    @(negedge clk);
    bin_in   = v;
    in_valid = 1'b1;
    enable   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bin_in   = '1;
    k = 0;
    while (!out_valid && k < 300) begin
      in_valid = ((k + 1) == dup_edge);
      enable   = !(((k + 1) >= off_start) && ((k + 1) < off_start + off_len));
      @(negedge clk);
      k++;
      if (k == 30) chk("ready_busy", 128'(ready), 128'(0));
      if (dup_edge > 0 && k == dup_edge)
        chk("overrun", 128'({overrun, overrun_lb, overrun_n3}), 128'(3'b111));
      if (dup_edge > 0 && k == dup_edge + 1)
        chk("overrun_end", 128'(overrun), 128'(0));
      if (off_len > 0 && k == off_start + 1)
        chk("ready_frozen", 128'(ready), 128'(0));
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    chk("latency", 128'(k), 128'(exp_lat));
    chk("ov_all", 128'({out_valid_lb, out_valid_n3}), 128'(2'b11));
    @(negedge clk);
    chk("ov_pulse", 128'(out_valid), 128'(0));
    chk("ready_all", 128'({ready, ready_lb, ready_n3}), 128'(3'b111));
  endtask

  task automatic check_all(input logic [127:0] e_d, input logic [127:0] e_lb,
                           input logic [95:0] e_n3, input logic [3:0] e_neg,
                           input logic [3:0] e_sat_n3);
    chk("ascii_d", ascii_d, e_d);
    chk("ascii_lb", ascii_lb, e_lb);
    chk("ascii_n3", 128'(ascii_n3), 128'(e_n3));
    chk("neg_d", 128'(neg_d), 128'(e_neg));
    chk("neg_lb", 128'(neg_lb), 128'(e_neg));
    chk("neg_n3", 128'(neg_n3), 128'(e_neg));
    chk("sat_d", 128'({sat_d, sat_lb}), 128'(0));
    chk("sat_n3", 128'(sat_n3), 128'(e_sat_n3));
  endtask

  task automatic check_reset_vals();
    chk("rst_ascii_d", ascii_d, {16{8'h30}});
    chk("rst_ascii_lb", ascii_lb, {16{8'h30}});
    chk("rst_ascii_n3", 128'(ascii_n3), 128'({12{8'h30}}));
    chk("rst_flags", 128'({neg_d, sat_d, neg_n3, sat_n3}), 128'(0));
    chk("rst_pulses", 128'({out_valid, overrun}), 128'(0));
  endtask

  localparam logic [51:0] V_B = {13'h1000, 13'd4095, 13'd1, 13'd0};
  localparam logic [51:0] V_C = {13'd999, 13'h1F9C, 13'd1234, 13'h1FF9};
  localparam logic [51:0] V_D = {13'd5, 13'd1000, 13'h1000, 13'd1234};
  localparam logic [51:0] V_E = {13'h1FFF, 13'd2048, 13'd77, 13'd300};

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    bin_in   = V_B;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(ready), 128'(1));
    repeat (10) @(negedge clk);
    chk("idle_no_ov", 128'(ov_pulses), 128'(0));
    check_reset_vals();

    // in_valid with enable low in IDLE is ignored
    enable   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dis_idle", 128'({ready, overrun}), 128'(2'b10));
    end
    enable   = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("dis_no_capture", 128'(ready), 128'(1));

    run_conv(V_B, 0, 0, 0, 61);
    check_all({"4096", "4095", "0001", "0000"}, {"4096", "4095", "   1", "   0"},
              {"999", "999", "  1", "  0"}, 4'b1000, 4'b1100);

    run_conv(V_C, 0, 0, 0, 61);
    check_all({"0999", "0100", "1234", "0007"}, {" 999", " 100", "1234", "   7"},
              {"999", "100", "999", "  7"}, 4'b0101, 4'b0010);

    // in_valid during DONE: overrun, no new conversion
    run_conv(V_D, 61, 0, 0, 61);
    check_all({"0005", "1000", "4096", "1234"}, {"   5", "1000", "4096", "1234"},
              {"  5", "999", "999", "999"}, 4'b0010, 4'b0111);

    // re-strobe at edge 10, enable low for 5 edges mid-SHIFT
    run_conv(V_E, 10, 20, 5, 66);
    check_all({"0001", "2048", "0077", "0300"}, {"   1", "2048", "  77", " 300"},
              {"  1", "999", " 77", "300"}, 4'b1000, 4'b0100);

    // reset at edge 20 of a conversion aborts it
    @(negedge clk);
    bin_in   = V_C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals();
    chk("ready_abort", 128'(ready), 128'(1));
    snap = ov_pulses;
    repeat (80) @(negedge clk);
    chk("abort_no_ov", 128'(ov_pulses), 128'(snap));

    run_conv(V_B, 0, 0, 0, 61);
    check_all({"4096", "4095", "0001", "0000"}, {"4096", "4095", "   1", "   0"},
              {"999", "999", "  1", "  0"}, 4'b1000, 4'b1100);

    repeat (5) @(negedge clk);
    chk("ov_total", 128'(ov_pulses), 128'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
